pipeline_stall_controller: RTL

//  Central freeze/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).

---
 rtl/pipeline_stall_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Purpose: freeze/flush sequencer for the 5-stage pipeline; merges hazard, branch flush and memory waits.
// Latency: control outputs are combinational (same cycle); counters and memTimeout state update on the next clk edge.
// Backpressure: an outstanding memory access freezes every stage until memReady; the FAULT state freezes them permanently.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hazard,
    input  logic                 branchTaken,
    input  logic                 memRequest,
    input  logic                 memReady,
    input  logic                 clearCounters,
    output logic                 freezePC,
    output logic                 freezeIfId,
    output logic                 flushIfId,
    output logic                 flushIdExe,
    output logic                 freezeBack,
    output logic                 memTimeout,
    output logic [CNT_WIDTH-1:0] stallCycles,
    output logic [CNT_WIDTH-1:0] flushCount
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              mem_stall;
    logic              fz_pc, fz_ifid, fl_ifid, fl_idexe, fz_back;

    // State and wait-cycle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state, memory stall decode and prioritised freeze/flush controls.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        fz_pc        = 1'b0;
        fz_ifid      = 1'b0;
        fl_ifid      = 1'b0;
        fl_idexe     = 1'b0;
        fz_back      = 1'b0;

        case (state)
            RUN: begin
                // A request completing in the same cycle is a single-cycle access.
                mem_stall = memRequest & ~memReady;
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                // A dropped request abandons the wait without freezing this cycle.
                mem_stall = memRequest & ~memReady;
                if (memReady || !memRequest) begin
                    state_nxt = RUN;
                end else if (MEM_TIMEOUT != 0 && wait_cnt == WAIT_MAX) begin
                    state_nxt = FAULT;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            FAULT: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // Memory stall beats branch flush, which beats the hazard bubble.
        if (mem_stall) begin
            fz_pc   = 1'b1;
            fz_ifid = 1'b1;
            fz_back = 1'b1;
        end else if (branchTaken) begin
            fl_ifid  = 1'b1;
            fl_idexe = 1'b1;
        end else if (hazard) begin
            fz_pc    = 1'b1;
            fz_ifid  = 1'b1;
            fl_idexe = 1'b1;
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign freezePC   = rst_n & fz_pc;
    assign freezeIfId = rst_n & fz_ifid;
    assign flushIfId  = rst_n & fl_ifid;
    assign flushIdExe = rst_n & fl_idexe;
    assign freezeBack = rst_n & fz_back;
    assign memTimeout = rst_n & (state == FAULT);

    // Saturating stall-cycle counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles <= '0;
        end else if (clearCounters) begin
            stallCycles <= '0;
        end else if ((freezePC | freezeBack) && stallCycles != '1) begin
            stallCycles <= stallCycles + CNT_WIDTH'(1);
        end
    end

    // Saturating branch-flush counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flushCount <= '0;
        end else if (clearCounters) begin
            flushCount <= '0;
        end else if (flushIfId && flushCount != '1) begin
            flushCount <= flushCount + CNT_WIDTH'(1);
        end
    end

endmodule
